// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader: FSM state encoding and word/byte sizing.
package boot_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      WAIT = 3'd2,
      WR   = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } boot_state_e;

   localparam int unsigned BITS_PER_BYTE = 8;

   // Destination addresses advance by this many bytes per copied word.
   function automatic int unsigned bytes_per_word(input int unsigned data_width);
      return data_width / BITS_PER_BYTE;
   endfunction

endpackage

// File: rtl/boot_loader.sv
// One-shot boot copier: moves len words from the boot ROM to a byte-addressed
// destination memory, then raises a sticky core fetch enable.
module boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ROM_WORDS  = 1024,
   parameter int unsigned DST_AW     = 32
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic                          start_i,
   input  logic [$clog2(ROM_WORDS):0]    len_i,
   input  logic [DST_AW-1:0]             dst_base_i,
   output logic                          rom_req_o,
   output logic [$clog2(ROM_WORDS)-1:0]  rom_addr_o,
   input  logic [DATA_WIDTH-1:0]         rom_rdata_i,
   output logic                          mem_req_o,
   output logic                          mem_we_o,
   output logic [DST_AW-1:0]             mem_addr_o,
   output logic [DATA_WIDTH-1:0]         mem_wdata_o,
   output logic [DATA_WIDTH/8-1:0]       mem_be_o,
   input  logic                          mem_gnt_i,
   output logic                          busy_o,
   output logic                          done_o,
   output logic                          err_o,
   output logic                          fetch_en_o
);

   localparam int unsigned AW  = $clog2(ROM_WORDS);
   localparam int unsigned LW  = AW + 1;
   localparam int unsigned BPW = bytes_per_word(DATA_WIDTH);

   boot_state_e             state_q, state_d;
   logic [AW-1:0]           idx_q, idx_d;
   logic [LW-1:0]           len_q, len_d;
   logic [DST_AW-1:0]       base_q, base_d;
   logic [DATA_WIDTH-1:0]   data_q, data_d;
   logic                    fetch_en_q;

   logic                    last_word;
   logic [DST_AW-1:0]       wr_addr;

   assign last_word = ({1'b0, idx_q} == (len_q - LW'(1)));

   // Byte offset wraps modulo 2^DST_AW by construction of the adder width.
   assign wr_addr = base_q + (DST_AW'(idx_q) * DST_AW'(BPW));

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= IDLE;
         idx_q      <= '0;
         len_q      <= '0;
         base_q     <= '0;
         data_q     <= '0;
         fetch_en_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         base_q  <= base_d;
         data_q  <= data_d;
         if (state_d == DONE) begin
            fetch_en_q <= 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      len_d       = len_q;
      base_d      = base_q;
      data_d      = data_q;

      rom_req_o   = 1'b0;
      rom_addr_o  = '0;
      mem_req_o   = 1'b0;
      mem_we_o    = 1'b0;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_be_o    = '0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      err_o       = 1'b0;
      fetch_en_o  = fetch_en_q;

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (len_i > LW'(ROM_WORDS)) begin
                  state_d = ERR;
               end else if (len_i == '0) begin
                  state_d = DONE;
               end else begin
                  len_d   = len_i;
                  base_d  = dst_base_i;
                  idx_d   = '0;
                  state_d = RD;
               end
            end
         end

         RD: begin
            busy_o     = 1'b1;
            rom_req_o  = 1'b1;
            rom_addr_o = idx_q;
            state_d    = WAIT;
         end

         WAIT: begin
            busy_o  = 1'b1;
            data_d  = rom_rdata_i;
            state_d = WR;
         end

         // Request, address and data stay put until the destination grants.
         WR: begin
            busy_o      = 1'b1;
            mem_req_o   = 1'b1;
            mem_we_o    = 1'b1;
            mem_addr_o  = wr_addr;
            mem_wdata_o = data_q;
            mem_be_o    = '1;
            if (mem_gnt_i) begin
               if (last_word) begin
                  state_d = DONE;
               end else begin
                  idx_d   = idx_q + AW'(1);
                  state_d = RD;
               end
            end
         end

         DONE: begin
            done_o = 1'b1;
         end

         ERR: begin
            err_o = 1'b1;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

endmodule
